// File: rtl/serial_arith_pkg.sv
// Shared constants and FSM state encoding for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, bout set when that underflows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out for one bit position.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last completed result
// SHIFT | one difference bit per cycle, count = bit index
// DONE  | single-cycle done pulse; start here chains the next job
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             diff_bit
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Only the upper WIDTH-1 collected bits are kept; the final bit goes
  // straight from the cell into the result.
  logic [WIDTH-2:0] d_sh;
  logic [WIDTH-1:0] d_sh_next;
  logic             bw;
  logic             d;
  logic             bout;
  logic             accept;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (bw),
    .d    (d),
    .bout (bout)
  );

  // Handshake decode and the collected difference including this cycle's bit.
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last_bit  = (state == SHIFT) && (count == CW'(WIDTH - 1));
    d_sh_next = {d, d_sh};
    busy      = (state == SHIFT);
    done      = (state == DONE);
    diff_bit  = (state == SHIFT) ? d : 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand load, serial shifting, and result capture on completion.
  always_ff @(posedge clk) begin
    if (clear) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      bw     <= 1'b0;
      count  <= '0;
      result <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      bw    <= 1'b0;
      count <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      d_sh  <= d_sh_next[WIDTH-1:1];
      bw    <= bout;
      count <= count + 1'b1;
      if (last_bit) begin
        result <= d_sh_next;
        borrow <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a scoreboard of expected completions.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, diff_bit;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         bor;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;
  int   last_done_edge = -1;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .borrow   (borrow),
    .diff_bit (diff_bit)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge, then check done against the scoreboard and pop on completion.
  task automatic step();
    logic exp_done;
    exp_t e;
    @(posedge clk);
    #1;
    edges++;
    exp_done = (sb.size() > 0) && (sb[0].due == edges);
    chk("done", {31'b0, done}, {31'b0, exp_done});
    if (exp_done) begin
      e = sb.pop_front();
      last_done_edge = edges;
      chk("result", {24'b0, result}, {24'b0, e.res});
      chk("borrow", {31'b0, borrow}, {31'b0, e.bor});
    end
  endtask

  // Present operands with start; the job is expected to be accepted on the next edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    e.res = av - bv;
    e.bor = (av < bv);
    e.due = edges + 1 + W;
    sb.push_back(e);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] exp_bits;
    logic [W-1:0] held_res;
    logic         held_bor;
    int           first_done;

    clear = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    clear = 1'b0;
    step();
    chk("rst_busy",   {31'b0, busy},     0);
    chk("rst_result", {24'b0, result},   0);
    chk("rst_borrow", {31'b0, borrow},   0);
    chk("rst_diff",   {31'b0, diff_bit}, 0);

    // Basic 7 - 3 with serial bit trace.
    exp_bits = 8'h04;
    issue(8'h07, 8'h03);
    step();
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 1);
    chk("diff_bit0", {31'b0, diff_bit}, {31'b0, exp_bits[0]});
    for (int i = 1; i < W; i++) begin
      step();
      chk($sformatf("diff_bit%0d", i), {31'b0, diff_bit}, {31'b0, exp_bits[i]});
    end
    drain(20);
    chk("busy_after_done", {31'b0, busy}, 0);
    step();
    chk("diff_idle", {31'b0, diff_bit}, 0);

    // Underflow cases.
    issue(8'h03, 8'h07);
    step();
    start = 1'b0;
    drain(20);
    issue(8'h00, 8'h01);
    step();
    start = 1'b0;
    drain(20);

    // Back-to-back with start held high.
    issue(8'h06, 8'h04);
    step();
    for (int i = 0; i < W; i++) step();
    first_done = last_done_edge;
    chk("b2b_first_done", {31'b0, done}, 1);
    issue(8'hFF, 8'hFF);
    step();
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 1);
    drain(20);
    chk("b2b_gap", last_done_edge - first_done, W + 1);

    // Start while busy is ignored.
    issue(8'h07, 8'h03);
    step();
    start = 1'b0;
    step();
    step();
    step();
    start = 1'b1;
    a     = 8'h55;
    step();
    start = 1'b0;
    drain(20);
    chk("busy_start_queue", sb.size(), 0);

    // Clear mid-operation at count 4 of 0x80 - 0x01.
    a     = 8'h80;
    b     = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_clear_busy", {31'b0, busy}, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_busy",   {31'b0, busy},     0);
    chk("clr_result", {24'b0, result},   0);
    chk("clr_borrow", {31'b0, borrow},   0);
    chk("clr_diff",   {31'b0, diff_bit}, 0);
    for (int i = 0; i < 12; i++) step();
    issue(8'h80, 8'h01);
    step();
    start = 1'b0;
    drain(20);

    // Hold: operands wander with start low, outputs must not move.
    held_res = result;
    held_bor = borrow;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      step();
      chk("hold_result", {24'b0, result}, {24'b0, held_res});
      chk("hold_borrow", {31'b0, borrow}, {31'b0, held_bor});
    end

    // A few random operations.
    for (int i = 0; i < 6; i++) begin
      issue(W'($urandom), W'($urandom));
      step();
      start = 1'b0;
      drain(20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: the inverse operation to the lab's serial adder. Loads two WIDTH-bit operands in parallel, computes a − b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop, then presents the parallel difference and final borrow. A start/busy/done handshake lets a controller or testbench chain operations back to back.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous reset, active high.
- start  in  1  request; sampled only while idle or while done is high.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- busy  out  1  high while a subtraction is in progress.
- done  out  1  one-cycle pulse when result and borrow become valid.
- result  out  WIDTH  a − b mod 2^WIDTH; held until the next completion.
- borrow  out  1  high when a < b as unsigned values; held with result.
- diff_bit  out  1  serial difference bit produced in the current SHIFT cycle; 0 outside SHIFT.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start = 1, the FSM loads A_sh ← a, B_sh ← b, clears the borrow flip-flop bw and the count, and enters SHIFT. Otherwise it stays in IDLE.
- SHIFT, each cycle:
  - d = A_sh[0] ^ B_sh[0] ^ bw.
  - bw_next = (~A_sh[0] & B_sh[0]) | (~(A_sh[0] ^ B_sh[0]) & bw).
  - A_sh and B_sh shift right by one.
  - The internal D_sh shifts right, inserting d at the MSB.
  - count increments.
- On the cycle where count = WIDTH−1:
  - result ← {d, D_sh[WIDTH-1:1]}.
  - borrow ← bw_next.
  - The FSM enters DONE.
- DONE: done = 1 for this single state.
  - If start = 1, the new operands are loaded and the FSM returns to SHIFT (back-to-back operation, no IDLE gap).
  - Otherwise the FSM goes to IDLE.
- busy = 1 in SHIFT only. start is ignored while busy.
- result and borrow change only on the completion edge. They are never partially updated.
- Arithmetic is unsigned subtraction mod 2^WIDTH. borrow is the unsigned-underflow flag, equal to the inverted carry of a + ~b + 1.
- Reset values: state = IDLE; busy, done, borrow, diff_bit = 0; result = 0. All internal registers also reset to 0.
- clear has priority over every other input in every state. Asserting it mid-SHIFT aborts the operation. No done pulse is produced, and result and borrow revert to 0.

## Timing
- Let E0 be the edge where start is accepted.
  - busy rises after E0.
  - Bit i is computed in the cycle after edge E0+i, for i = 0..WIDTH−1.
  - On edge E0+WIDTH: result and borrow update, done rises, and busy falls.
- done is high for exactly one cycle, WIDTH edges after acceptance.
- Throughput: one operation every WIDTH+1 cycles when start is held high.
- Operands a and b need to be valid only at the accepting edge.

## Structure
- Shared package serial_arith_pkg:
  - default WIDTH constant.
  - FSM state typedef (IDLE/SHIFT/DONE), 2 bits.
  - count width constant = $clog2(WIDTH).
- One sub-module, full_subtractor (combinational):
  - inputs x, y, bin.
  - outputs d, bout.
  - instantiated once in the datapath.
- Top level: FSM, counter, three shift registers, borrow flip-flop, output registers.

## Test plan
- Basic subtraction: a=8'h07, b=8'h03, start pulsed one cycle.
  - Required: done exactly 8 edges after acceptance, result=8'h04, borrow=0.
  - Required: diff_bit sequence 0,0,1,0,0,0,0,0.
- Underflow cases:
  - a=8'h03, b=8'h07 → result=8'hFC, borrow=1.
  - a=8'h00, b=8'h01 → result=8'hFF, borrow=1.
- Back-to-back: start held high.
  - First operation a=8'h06, b=8'h04 → result=8'h02.
  - Second operands a=8'hFF, b=8'hFF presented during DONE → accepted with no IDLE cycle, result=8'h00, borrow=0, done 9 cycles after the first done.
- Start while busy: pulse start with a=8'h55 at count=3 of an 8'h07−8'h03 operation.
  - Required: the pulse is ignored and the final result is still 8'h04.
- Reset: clear asserted at count=4 of 8'h80−8'h01.
  - Required next cycle: state IDLE, busy=0, done never pulses, result=0, borrow=0.
  - Then a new 8'h80−8'h01 run gives 8'h7F, borrow=0.
- Hold: after any completion, toggle a and b randomly for 20 cycles with start=0.
  - Required: result, borrow and done stay unchanged.
